// File: rtl/scariv_ic_pkg.sv
// Shared types and constants for the instruction-side L2 arbiter.
// Holds the address/line types, the L2 source tags, the demand and
// prefetch slot state enums and the line-address helper.
package scariv_ic_pkg;

    localparam int PADDR_W         = 32;
    localparam int ICACHE_DATA_W   = 256;
    localparam int ICACHE_DATA_B_W = ICACHE_DATA_W / 8;
    localparam int IC_LINE_OFS_W   = $clog2(ICACHE_DATA_B_W);

    typedef logic [PADDR_W-1:0]       paddr_t;
    typedef logic [ICACHE_DATA_W-1:0] ic_data_t;

    localparam int IC_L2_TAG_DEMAND = 0;
    localparam int IC_L2_TAG_PREF   = 1;

    typedef enum logic [1:0] {
        DIdle,
        DWait,
        DMerged,
        DKill
    } ic_l2_dem_state_t;

    typedef enum logic {
        PIdle,
        PWait
    } ic_l2_pref_state_t;

    // Zero the byte offset within an i-cache line.
    function automatic paddr_t ic_line_addr(input paddr_t addr);
        return {addr[PADDR_W-1:IC_LINE_OFS_W], {IC_LINE_OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/scariv_ic_l2_arb.sv
// Instruction-side L2 arbiter: shares one L2 request/response channel
// between the i-cache demand-miss path and the instruction prefetcher.
// Demand wins by default; a starving prefetch gets one priority grant.
// A demand miss to the line of an in-flight prefetch merges into it.
// Optional build macro SCARIV_IC_L2_ARB_PERF_EN adds 32-bit saturating
// performance counters.
module scariv_ic_l2_arb
    import scariv_ic_pkg::*;
#(
    parameter int PREF_STARVE_MAX = 8,
    parameter int L2_TAG_W        = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_flush_valid,
    input  logic                i_fence_i,

    input  logic                i_demand_req_valid,
    output logic                o_demand_req_ready,
    input  paddr_t              i_demand_req_paddr,
    output logic                o_demand_resp_valid,
    output ic_data_t            o_demand_resp_data,

    input  logic                i_pref_req_valid,
    output logic                o_pref_req_ready,
    input  paddr_t              i_pref_req_paddr,
    output logic                o_pref_resp_valid,
    output ic_data_t            o_pref_resp_data,

    output logic                o_l2_req_valid,
    input  logic                i_l2_req_ready,
    output paddr_t              o_l2_req_paddr,
    output logic [L2_TAG_W-1:0] o_l2_req_tag,
    input  logic                i_l2_resp_valid,
    input  logic [L2_TAG_W-1:0] i_l2_resp_tag,
    input  ic_data_t            i_l2_resp_data
`ifdef SCARIV_IC_L2_ARB_PERF_EN
    ,
    output logic [31:0]         o_perf_demand_req_cnt,
    output logic [31:0]         o_perf_pref_req_cnt,
    output logic [31:0]         o_perf_merge_cnt,
    output logic [31:0]         o_perf_starve_cnt
`endif
);

    localparam int CNT_W = $clog2(PREF_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]    STARVE_MAX = CNT_W'(PREF_STARVE_MAX);
    localparam logic [L2_TAG_W-1:0] TAG_DEM    = L2_TAG_W'(IC_L2_TAG_DEMAND);
    localparam logic [L2_TAG_W-1:0] TAG_PREF   = L2_TAG_W'(IC_L2_TAG_PREF);

    ic_l2_dem_state_t  dem_q,  dem_d;
    ic_l2_pref_state_t pref_q, pref_d;
    paddr_t            pref_line_q, pref_line_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    paddr_t dem_line;
    paddr_t pref_line;
    logic   resp_dem;
    logic   resp_pref;
    logic   merge;
    logic   dem_elig;
    logic   pref_elig;
    logic   grant_pref;
    logic   grant_dem;
    logic   dem_fire;
    logic   pref_fire;
    logic   pref_resp_hit;
    logic   dem_resp_hit;
    logic   unexpected_resp;

    // Request decode, merge detection and arbitration (purely combinational).
    always_comb begin
        dem_line  = ic_line_addr(i_demand_req_paddr);
        pref_line = ic_line_addr(i_pref_req_paddr);
        resp_dem  = i_l2_resp_valid && (i_l2_resp_tag == TAG_DEM);
        resp_pref = i_l2_resp_valid && (i_l2_resp_tag == TAG_PREF);

        // A PREF response in the same cycle frees the prefetch slot, so the
        // demand then arbitrates normally instead of merging.
        merge = i_demand_req_valid && (dem_q == DIdle) && (pref_q == PWait) &&
                (dem_line == pref_line_q) && !resp_pref && !i_flush_valid;

        dem_elig  = i_demand_req_valid && (dem_q == DIdle) && !merge && !i_flush_valid;
        pref_elig = i_pref_req_valid && (pref_q == PIdle) && !i_fence_i;

        grant_pref = pref_elig && (!dem_elig || (starve_q == STARVE_MAX));
        grant_dem  = dem_elig && !grant_pref;
        dem_fire   = grant_dem && i_l2_req_ready;
        pref_fire  = grant_pref && i_l2_req_ready;

        pref_resp_hit = resp_pref && (pref_q == PWait);
        dem_resp_hit  = !i_flush_valid &&
                        (((dem_q == DWait) && resp_dem) ||
                         ((dem_q == DMerged) && resp_pref));

        unexpected_resp = i_l2_resp_valid &&
                          ((resp_dem && !((dem_q == DWait) || (dem_q == DKill))) ||
                           (resp_pref && (pref_q != PWait)) ||
                           (!resp_dem && !resp_pref));
    end

    // Outputs, held at zero while reset is asserted.
    always_comb begin
        o_l2_req_valid      = 1'b0;
        o_l2_req_paddr      = '0;
        o_l2_req_tag        = '0;
        o_demand_req_ready  = 1'b0;
        o_pref_req_ready    = 1'b0;
        o_demand_resp_valid = 1'b0;
        o_pref_resp_valid   = 1'b0;
        o_demand_resp_data  = '0;
        o_pref_resp_data    = '0;
        if (i_reset_n) begin
            o_l2_req_valid      = dem_elig || pref_elig;
            o_l2_req_paddr      = grant_pref ? pref_line : dem_line;
            o_l2_req_tag        = grant_pref ? TAG_PREF : TAG_DEM;
            o_demand_req_ready  = merge || dem_fire;
            o_pref_req_ready    = pref_fire;
            o_demand_resp_valid = dem_resp_hit;
            o_pref_resp_valid   = pref_resp_hit;
            o_demand_resp_data  = i_l2_resp_data;
            o_pref_resp_data    = i_l2_resp_data;
        end
    end

    // Demand slot next state.
    always_comb begin
        // NOTE: default first so every path assigns dem_d; no latch is inferred.
        dem_d = dem_q;
        case (dem_q)
            DIdle: begin
                if (merge)         dem_d = DMerged;
                else if (dem_fire) dem_d = DWait;
            end
            DWait: begin
                if (resp_dem)           dem_d = DIdle;
                else if (i_flush_valid) dem_d = DKill;
            end
            DKill: begin
                if (resp_dem) dem_d = DIdle;
            end
            DMerged: begin
                if (i_flush_valid || resp_pref) dem_d = DIdle;
            end
            default: dem_d = DIdle;
        endcase
    end

    // Prefetch slot next state and in-flight line capture.
    always_comb begin
        pref_d      = pref_q;
        pref_line_d = pref_line_q;
        case (pref_q)
            PIdle: begin
                if (pref_fire) begin
                    pref_d      = PWait;
                    pref_line_d = pref_line;
                end
            end
            PWait: begin
                if (resp_pref) pref_d = PIdle;
            end
            default: pref_d = PIdle;
        endcase
    end

    // Starvation counter: counts cycles an eligible prefetch loses to demand.
    always_comb begin
        starve_d = starve_q;
        if (pref_fire || !pref_elig) begin
            starve_d = '0;
        end else if (grant_dem && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dem_q       <= DIdle;
            pref_q      <= PIdle;
            pref_line_q <= '0;
            starve_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from
            // the same pre-edge values.
            dem_q       <= dem_d;
            pref_q      <= pref_d;
            pref_line_q <= pref_line_d;
            starve_q    <= starve_d;
        end
    end

`ifdef SCARIV_IC_L2_ARB_PERF_EN
    logic [31:0] perf_dem_q, perf_pref_q, perf_merge_q, perf_starve_q;
    logic        starve_grant;

    assign starve_grant = pref_fire && dem_elig;

    // Saturating performance counters.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_dem_q    <= '0;
            perf_pref_q   <= '0;
            perf_merge_q  <= '0;
            perf_starve_q <= '0;
        end else begin
            if (dem_fire && (perf_dem_q != '1))        perf_dem_q    <= perf_dem_q + 1'b1;
            if (pref_fire && (perf_pref_q != '1))      perf_pref_q   <= perf_pref_q + 1'b1;
            if (merge && (perf_merge_q != '1))         perf_merge_q  <= perf_merge_q + 1'b1;
            if (starve_grant && (perf_starve_q != '1)) perf_starve_q <= perf_starve_q + 1'b1;
        end
    end

    assign o_perf_demand_req_cnt = perf_dem_q;
    assign o_perf_pref_req_cnt   = perf_pref_q;
    assign o_perf_merge_cnt      = perf_merge_q;
    assign o_perf_starve_cnt     = perf_starve_q;
`endif

`ifndef SYNTHESIS
    // Flag responses that have no waiting owner; they are dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            assert (!unexpected_resp)
            else $warning("scariv_ic_l2_arb: unexpected L2 response tag %0d dropped", i_l2_resp_tag);
        end
    end
`endif

endmodule

// File: tb/tb_scariv_ic_l2_arb.sv
// Directed self-checking bench for scariv_ic_l2_arb.
module tb_scariv_ic_l2_arb;
    import scariv_ic_pkg::*;

    localparam int L2_TAG_W = 2;

    logic                i_clk = 1'b0;
    logic                i_reset_n;
    logic                i_flush_valid;
    logic                i_fence_i;
    logic                i_demand_req_valid;
    logic                o_demand_req_ready;
    paddr_t              i_demand_req_paddr;
    logic                o_demand_resp_valid;
    ic_data_t            o_demand_resp_data;
    logic                i_pref_req_valid;
    logic                o_pref_req_ready;
    paddr_t              i_pref_req_paddr;
    logic                o_pref_resp_valid;
    ic_data_t            o_pref_resp_data;
    logic                o_l2_req_valid;
    logic                i_l2_req_ready;
    paddr_t              o_l2_req_paddr;
    logic [L2_TAG_W-1:0] o_l2_req_tag;
    logic                i_l2_resp_valid;
    logic [L2_TAG_W-1:0] i_l2_resp_tag;
    ic_data_t            i_l2_resp_data;
`ifdef SCARIV_IC_L2_ARB_PERF_EN
    logic [31:0] o_perf_demand_req_cnt, o_perf_pref_req_cnt;
    logic [31:0] o_perf_merge_cnt, o_perf_starve_cnt;
`endif

    int checks = 0;
    int errors = 0;

    scariv_ic_l2_arb #(.PREF_STARVE_MAX(8), .L2_TAG_W(L2_TAG_W)) dut (
        .i_clk               (i_clk),
        .i_reset_n           (i_reset_n),
        .i_flush_valid       (i_flush_valid),
        .i_fence_i           (i_fence_i),
        .i_demand_req_valid  (i_demand_req_valid),
        .o_demand_req_ready  (o_demand_req_ready),
        .i_demand_req_paddr  (i_demand_req_paddr),
        .o_demand_resp_valid (o_demand_resp_valid),
        .o_demand_resp_data  (o_demand_resp_data),
        .i_pref_req_valid    (i_pref_req_valid),
        .o_pref_req_ready    (o_pref_req_ready),
        .i_pref_req_paddr    (i_pref_req_paddr),
        .o_pref_resp_valid   (o_pref_resp_valid),
        .o_pref_resp_data    (o_pref_resp_data),
        .o_l2_req_valid      (o_l2_req_valid),
        .i_l2_req_ready      (i_l2_req_ready),
        .o_l2_req_paddr      (o_l2_req_paddr),
        .o_l2_req_tag        (o_l2_req_tag),
        .i_l2_resp_valid     (i_l2_resp_valid),
        .i_l2_resp_tag       (i_l2_resp_tag),
        .i_l2_resp_data      (i_l2_resp_data)
`ifdef SCARIV_IC_L2_ARB_PERF_EN
        ,
        .o_perf_demand_req_cnt (o_perf_demand_req_cnt),
        .o_perf_pref_req_cnt   (o_perf_pref_req_cnt),
        .o_perf_merge_cnt      (o_perf_merge_cnt),
        .o_perf_starve_cnt     (o_perf_starve_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change #1 after the edge, checks run #3 later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        i_flush_valid      = 1'b0;
        i_fence_i          = 1'b0;
        i_demand_req_valid = 1'b0;
        i_demand_req_paddr = '0;
        i_pref_req_valid   = 1'b0;
        i_pref_req_paddr   = '0;
        i_l2_req_ready     = 1'b0;
        i_l2_resp_valid    = 1'b0;
        i_l2_resp_tag      = '0;
        i_l2_resp_data     = '0;
    endtask

    task automatic respond(input logic [L2_TAG_W-1:0] tag, input ic_data_t data);
        i_l2_resp_valid = 1'b1;
        i_l2_resp_tag   = tag;
        i_l2_resp_data  = data;
    endtask

    ic_data_t d1, d2, d3, d4;

    initial begin
        d1 = {8{32'hA5A5_0001}};
        d2 = {8{32'h5A5A_0002}};
        d3 = {8{32'hC3C3_0003}};
        d4 = {8{32'h3C3C_0004}};

        // Reset: outputs stay 0 even with requests presented.
        idle_inputs();
        i_reset_n          = 1'b0;
        i_demand_req_valid = 1'b1;
        i_pref_req_valid   = 1'b1;
        i_l2_req_ready     = 1'b1;
        #12;
        check("rst_l2_valid", o_l2_req_valid, 0);
        check("rst_dem_ready", o_demand_req_ready, 0);
        check("rst_pref_ready", o_pref_req_ready, 0);
        check("rst_dem_state", dut.dem_q, DIdle);
        check("rst_pref_state", dut.pref_q, PIdle);
        check("rst_starve", dut.starve_q, 0);
        tick();
        idle_inputs();
        i_reset_n = 1'b1;
        tick();

        // Demand only, line-aligned request with tag 0.
        i_demand_req_valid = 1'b1;
        i_demand_req_paddr = 32'h8000_0044;
        i_l2_req_ready     = 1'b1;
        settle();
        check("t1_l2_valid", o_l2_req_valid, 1);
        check("t1_l2_paddr", o_l2_req_paddr, 32'h8000_0040);
        check("t1_l2_tag", o_l2_req_tag, 0);
        check("t1_dem_ready", o_demand_req_ready, 1);
        tick();
        idle_inputs();
        respond(0, d1);
        settle();
        check("t1_dem_resp", o_demand_resp_valid, 1);
        check("t1_dem_data", o_demand_resp_data, d1);
        check("t1_pref_resp", o_pref_resp_valid, 0);
        tick();
        idle_inputs();
        settle();
        check("t1_dem_resp_pulse", o_demand_resp_valid, 0);
        tick();

        // Starvation: L2 stalls so demand keeps winning without firing.
        i_demand_req_valid = 1'b1;
        i_demand_req_paddr = 32'h0000_2000;
        i_pref_req_valid   = 1'b1;
        i_pref_req_paddr   = 32'h0000_3004;
        for (int i = 1; i <= 8; i++) begin
            settle();
            check($sformatf("t2_tag_c%0d", i), o_l2_req_tag, 0);
            check($sformatf("t2_dem_ready_c%0d", i), o_demand_req_ready, 0);
            tick();
        end
        i_l2_req_ready = 1'b1;
        settle();
        check("t2_starve_full", dut.starve_q, 8);
        check("t2_c9_tag", o_l2_req_tag, 1);
        check("t2_c9_paddr", o_l2_req_paddr, 32'h0000_3000);
        check("t2_c9_pref_ready", o_pref_req_ready, 1);
        check("t2_c9_dem_ready", o_demand_req_ready, 0);
        tick();
        check("t2_starve_clr", dut.starve_q, 0);
        settle();
        check("t2_c10_tag", o_l2_req_tag, 0);
        check("t2_c10_dem_ready", o_demand_req_ready, 1);
        tick();
        idle_inputs();
        respond(1, d2);
        settle();
        check("t2_pref_resp", o_pref_resp_valid, 1);
        check("t2_pref_resp_dem", o_demand_resp_valid, 0);
        tick();
        idle_inputs();
        respond(0, d3);
        settle();
        check("t2_dem_resp", o_demand_resp_valid, 1);
        tick();
        idle_inputs();

        // Merge: demand 0x1010 into in-flight prefetch 0x1000, L2 not ready.
        i_pref_req_valid = 1'b1;
        i_pref_req_paddr = 32'h0000_1000;
        i_l2_req_ready   = 1'b1;
        settle();
        check("t3_pref_ready", o_pref_req_ready, 1);
        tick();
        idle_inputs();
        i_demand_req_valid = 1'b1;
        i_demand_req_paddr = 32'h0000_1010;
        settle();
        check("t3_merge_ready", o_demand_req_ready, 1);
        check("t3_merge_no_l2", o_l2_req_valid, 0);
        tick();
        idle_inputs();
        check("t3_dem_merged", dut.dem_q, DMerged);
        respond(1, d3);
        settle();
        check("t3_dem_resp", o_demand_resp_valid, 1);
        check("t3_pref_resp", o_pref_resp_valid, 1);
        check("t3_dem_data", o_demand_resp_data, d3);
        check("t3_pref_data", o_pref_resp_data, d3);
        tick();
        idle_inputs();
        check("t3_dem_idle", dut.dem_q, DIdle);

        // Match with PREF response in the same cycle: no merge, normal demand.
        i_pref_req_valid = 1'b1;
        i_pref_req_paddr = 32'h0000_1000;
        i_l2_req_ready   = 1'b1;
        tick();
        idle_inputs();
        i_demand_req_valid = 1'b1;
        i_demand_req_paddr = 32'h0000_1010;
        i_l2_req_ready     = 1'b1;
        respond(1, d4);
        settle();
        check("t3b_l2_valid", o_l2_req_valid, 1);
        check("t3b_l2_tag", o_l2_req_tag, 0);
        check("t3b_dem_ready", o_demand_req_ready, 1);
        check("t3b_pref_resp", o_pref_resp_valid, 1);
        check("t3b_dem_resp", o_demand_resp_valid, 0);
        tick();
        idle_inputs();
        check("t3b_dem_wait", dut.dem_q, DWait);
        respond(0, d1);
        tick();
        idle_inputs();

        // Flush while demand outstanding: its response is dropped.
        i_demand_req_valid = 1'b1;
        i_demand_req_paddr = 32'h0000_4000;
        i_l2_req_ready     = 1'b1;
        tick();
        idle_inputs();
        i_flush_valid = 1'b1;
        tick();
        idle_inputs();
        check("t4_dem_kill", dut.dem_q, DKill);
        respond(0, d2);
        i_demand_req_valid = 1'b1;
        i_demand_req_paddr = 32'h0000_5000;
        i_l2_req_ready     = 1'b1;
        settle();
        check("t4_killed_resp", o_demand_resp_valid, 0);
        check("t4_busy_ready", o_demand_req_ready, 0);
        tick();
        i_l2_resp_valid = 1'b0;
        settle();
        check("t4_next_ready", o_demand_req_ready, 1);
        tick();
        idle_inputs();
        respond(0, d1);
        tick();
        idle_inputs();

        // Flush in idle blocks demand acceptance.
        i_flush_valid      = 1'b1;
        i_demand_req_valid = 1'b1;
        i_demand_req_paddr = 32'h0000_5000;
        i_l2_req_ready     = 1'b1;
        settle();
        check("t4b_flush_ready", o_demand_req_ready, 0);
        check("t4b_flush_l2", o_l2_req_valid, 0);
        tick();
        idle_inputs();

        // Flush while merged: demand drops, prefetch still gets its line.
        i_pref_req_valid = 1'b1;
        i_pref_req_paddr = 32'h0000_9000;
        i_l2_req_ready   = 1'b1;
        tick();
        idle_inputs();
        i_demand_req_valid = 1'b1;
        i_demand_req_paddr = 32'h0000_901C;
        tick();
        idle_inputs();
        i_flush_valid = 1'b1;
        tick();
        idle_inputs();
        check("t4c_dem_idle", dut.dem_q, DIdle);
        respond(1, d2);
        settle();
        check("t4c_pref_resp", o_pref_resp_valid, 1);
        check("t4c_dem_resp", o_demand_resp_valid, 0);
        tick();
        idle_inputs();

        // fence.i blocks prefetch grants.
        i_fence_i        = 1'b1;
        i_pref_req_valid = 1'b1;
        i_pref_req_paddr = 32'h0000_6000;
        i_l2_req_ready   = 1'b1;
        settle();
        check("t5_fence_l2", o_l2_req_valid, 0);
        check("t5_fence_ready", o_pref_req_ready, 0);
        tick();
        i_fence_i = 1'b0;
        settle();
        check("t5_after_l2", o_l2_req_valid, 1);
        check("t5_after_tag", o_l2_req_tag, 1);
        check("t5_after_ready", o_pref_req_ready, 1);
        tick();
        idle_inputs();
        i_demand_req_valid = 1'b1;
        i_demand_req_paddr = 32'h0000_7000;
        i_l2_req_ready     = 1'b1;
        tick();
        idle_inputs();
        check("t6_dem_wait", dut.dem_q, DWait);
        check("t6_pref_wait", dut.pref_q, PWait);

        // Reset with both slots waiting, then stale responses.
        i_reset_n = 1'b0;
        #2;
        check("t6_rst_dem", dut.dem_q, DIdle);
        check("t6_rst_pref", dut.pref_q, PIdle);
        tick();
        i_reset_n = 1'b1;
        tick();
        respond(0, d1);
        settle();
        check("t6_stale0_dem", o_demand_resp_valid, 0);
        check("t6_stale0_pref", o_pref_resp_valid, 0);
        check("t6_stale0_flag", dut.unexpected_resp, 1);
        tick();
        respond(1, d2);
        settle();
        check("t6_stale1_dem", o_demand_resp_valid, 0);
        check("t6_stale1_pref", o_pref_resp_valid, 0);
        check("t6_stale1_flag", dut.unexpected_resp, 1);
        tick();
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
